// File: rtl/multicycle_add_ctrl.sv
// rtl/multicycle_add_ctrl.sv - operand launch / settle / capture controller around a ripple-carry adder
//
// Launches an operand pair onto the adder inputs, holds it stable for SETTLE
// clock edges while the carry chain settles, then captures the WIDTH+1 bit sum
// and offers it downstream on a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_valid, o_ready    operand handshake (i_a, i_b)
//   o_add1, o_add2      registered operands driving the adder inputs
//   i_sum               adder result, carry-out in the MSB
//   o_valid, i_ready    result handshake (o_result)
//   o_busy              high whenever not idle
//   o_count             completed transactions, modulo 256

module multicycle_add_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_add1,
    output logic [WIDTH-1:0] o_add2,
    input  logic [WIDTH:0]   i_sum,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_busy,
    output logic [7:0]       o_count
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] settle_cnt;

    // Only the handshake/busy flags are decoded from state; everything else is
    // a flop so the adder inputs never see combinational glitches.
    assign o_ready = (state == ST_IDLE);
    assign o_busy  = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            o_add1     <= '0;
            o_add2     <= '0;
            o_result   <= '0;
            o_valid    <= 1'b0;
            o_count    <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        o_add1     <= i_a;
                        o_add2     <= i_b;
                        settle_cnt <= CNT_LOAD;
                        state      <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    // The adder output is only trusted on the last edge of the
                    // window; anything it does before that is ignored.
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end else begin
                        o_result <= i_sum;
                        o_valid  <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_count <= o_count + 8'd1;
                        state   <= ST_IDLE;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_add_ctrl.sv
// tb/tb_multicycle_add_ctrl.sv - directed self-checking bench for multicycle_add_ctrl

module tb_multicycle_add_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 i_clk = ~i_clk;

    // Instance A: SETTLE = 3, adder model with 25 ns delay.
    logic       a_valid, a_ready, a_ovalid, a_iready, a_busy;
    logic [7:0] a_a, a_b, a_add1, a_add2, a_count;
    logic [8:0] a_sum, a_result;

    // Instance B: SETTLE = 1, adder model with 4 ns delay.
    logic       b_valid, b_ready, b_ovalid, b_iready, b_busy;
    logic [7:0] b_a, b_b, b_add1, b_add2, b_count;
    logic [8:0] b_sum, b_result;

    always @(a_add1 or a_add2) a_sum <= #25 {1'b0, a_add1} + {1'b0, a_add2};
    always @(b_add1 or b_add2) b_sum <= #4 {1'b0, b_add1} + {1'b0, b_add2};

    multicycle_add_ctrl #(.WIDTH(8), .SETTLE(3)) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(a_valid), .o_ready(a_ready),
        .i_a(a_a), .i_b(a_b),
        .o_add1(a_add1), .o_add2(a_add2),
        .i_sum(a_sum),
        .o_valid(a_ovalid), .i_ready(a_iready),
        .o_result(a_result), .o_busy(a_busy), .o_count(a_count)
    );

    multicycle_add_ctrl #(.WIDTH(8), .SETTLE(1)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(b_valid), .o_ready(b_ready),
        .i_a(b_a), .i_b(b_b),
        .o_add1(b_add1), .o_add2(b_add2),
        .i_sum(b_sum),
        .o_valid(b_ovalid), .i_ready(b_iready),
        .o_result(b_result), .o_busy(b_busy), .o_count(b_count)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Full transaction on instance A with i_ready held low until the result is seen.
    task automatic run_txn(input logic [7:0] x, input logic [7:0] y,
                           input logic [8:0] exp, input logic [7:0] exp_cnt);
        a_valid = 1'b1; a_a = x; a_b = y; a_iready = 1'b0;
        tick();                                   // edge k: accept
        a_valid = 1'b0;
        checks++; if (a_add1 !== x || a_add2 !== y) begin errors++;
            $display("FAIL txn_launch got %h/%h exp %h/%h", a_add1, a_add2, x, y); end
        checks++; if (a_ready !== 1'b0 || a_busy !== 1'b1) begin errors++;
            $display("FAIL txn_busy got ready=%b busy=%b exp 0/1", a_ready, a_busy); end
        tick(); tick();                           // edges k+1, k+2
        checks++; if (a_ovalid !== 1'b0) begin errors++;
            $display("FAIL txn_early_valid got %b exp 0", a_ovalid); end
        tick();                                   // edge k+3: capture
        checks++; if (a_ovalid !== 1'b1 || a_result !== exp) begin errors++;
            $display("FAIL txn_capture got valid=%b result=%h exp 1/%h", a_ovalid, a_result, exp); end
        a_iready = 1'b1;
        tick();
        a_iready = 1'b0;
        checks++; if (a_ovalid !== 1'b0 || a_ready !== 1'b1 || a_count !== exp_cnt) begin errors++;
            $display("FAIL txn_release got valid=%b ready=%b count=%0d exp 0/1/%0d",
                     a_ovalid, a_ready, a_count, exp_cnt); end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'($urandom); a_a = 8'($urandom); a_b = 8'($urandom); a_iready = 1'($urandom);
            b_valid = 1'($urandom); b_a = 8'($urandom); b_b = 8'($urandom); b_iready = 1'($urandom);
            tick();
            checks++; if ({a_ready, a_ovalid, a_busy} !== 3'b100 || a_add1 !== 8'h00 ||
                          a_add2 !== 8'h00 || a_result !== 9'h000 || a_count !== 8'h00) begin errors++;
                $display("FAIL reset_a got rdy=%b vld=%b busy=%b add=%h/%h res=%h cnt=%h exp 1/0/0 00/00 000 00",
                         a_ready, a_ovalid, a_busy, a_add1, a_add2, a_result, a_count); end
            checks++; if ({b_ready, b_ovalid, b_busy} !== 3'b100 || b_add1 !== 8'h00 ||
                          b_result !== 9'h000 || b_count !== 8'h00) begin errors++;
                $display("FAIL reset_b got rdy=%b vld=%b busy=%b add1=%h res=%h cnt=%h exp 1/0/0 00 000 00",
                         b_ready, b_ovalid, b_busy, b_add1, b_result, b_count); end
        end
        a_valid = 1'b0; a_iready = 1'b0; b_valid = 1'b0; b_iready = 1'b0;
        a_a = 8'hA5; a_b = 8'h5A;
        #3 i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_add1 !== 8'h00 || a_add2 !== 8'h00) begin errors++;
                $display("FAIL idle_after_reset got rdy=%b busy=%b add=%h/%h exp 1/0 00/00",
                         a_ready, a_busy, a_add1, a_add2); end
        end
    endtask

    task automatic test_basic();
        run_txn(8'h0F, 8'h01, 9'h010, 8'd1);
    endtask

    task automatic test_carry();
        run_txn(8'hFF, 8'h01, 9'h100, 8'd2);
        run_txn(8'hFF, 8'hFF, 9'h1FE, 8'd3);
        run_txn(8'h00, 8'h00, 9'h000, 8'd4);
    endtask

    task automatic test_backpressure();
        a_valid = 1'b1; a_a = 8'h12; a_b = 8'h34; a_iready = 1'b0;
        tick();                                   // accept
        a_a = 8'h55; a_b = 8'h66;                 // new operands offered throughout
        tick(); tick(); tick();                   // capture at k+3
        checks++; if (a_ovalid !== 1'b1 || a_result !== 9'h046) begin errors++;
            $display("FAIL bp_capture got valid=%b result=%h exp 1/046", a_ovalid, a_result); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (a_result !== 9'h046 || a_add1 !== 8'h12 || a_add2 !== 8'h34 ||
                          a_ready !== 1'b0 || a_ovalid !== 1'b1 || a_count !== 8'd4) begin errors++;
                $display("FAIL bp_hold got res=%h add=%h/%h rdy=%b vld=%b cnt=%0d exp 046 12/34 0 1 4",
                         a_result, a_add1, a_add2, a_ready, a_ovalid, a_count); end
        end
        a_iready = 1'b1;
        tick();                                   // release
        a_iready = 1'b0;
        checks++; if (a_count !== 8'd5 || a_ready !== 1'b1 || a_add1 !== 8'h12) begin errors++;
            $display("FAIL bp_release got cnt=%0d rdy=%b add1=%h exp 5/1/12", a_count, a_ready, a_add1); end
        tick();                                   // next operands accepted
        a_valid = 1'b0;
        checks++; if (a_add1 !== 8'h55 || a_add2 !== 8'h66 || a_busy !== 1'b1) begin errors++;
            $display("FAIL bp_next_accept got add=%h/%h busy=%b exp 55/66/1", a_add1, a_add2, a_busy); end
        tick(); tick(); tick();
        checks++; if (a_ovalid !== 1'b1 || a_result !== 9'h0BB) begin errors++;
            $display("FAIL bp_next_result got valid=%b result=%h exp 1/0bb", a_ovalid, a_result); end
        a_iready = 1'b1;
        tick();
        a_iready = 1'b0;
        checks++; if (a_count !== 8'd6) begin errors++;
            $display("FAIL bp_count got %0d exp 6", a_count); end
    endtask

    task automatic test_reset_mid_settle();
        a_valid = 1'b1; a_a = 8'h01; a_b = 8'h02; a_iready = 1'b1;
        tick();                                   // accept, counter = 2
        a_valid = 1'b0;
        tick();                                   // counter = 1
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if ({a_ready, a_ovalid, a_busy} !== 3'b100 || a_add1 !== 8'h00 ||
                      a_result !== 9'h000 || a_count !== 8'h00) begin errors++;
            $display("FAIL mid_reset got rdy=%b vld=%b busy=%b add1=%h res=%h cnt=%0d exp 1/0/0 00 000 0",
                     a_ready, a_ovalid, a_busy, a_add1, a_result, a_count); end
        #2 i_rst_n = 1'b1;
        tick();
        checks++; if (a_ovalid !== 1'b0 || a_count !== 8'd0) begin errors++;
            $display("FAIL mid_reset_after got vld=%b cnt=%0d exp 0/0", a_ovalid, a_count); end
        run_txn(8'h80, 8'h80, 9'h100, 8'd1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] x, y;
        logic [8:0] e;
        b_valid = 1'b1; b_iready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            x = 8'(n); y = 8'(n) ^ 8'h5A;
            e = {1'b0, x} + {1'b0, y};
            b_a = x; b_b = y;
            tick();                               // accept
            checks++; if (b_add1 !== x || b_add2 !== y || b_ovalid !== 1'b0) begin errors++;
                $display("FAIL b2b_accept n=%0d got %h/%h vld=%b exp %h/%h 0", n, b_add1, b_add2, b_ovalid, x, y); end
            tick();                               // capture one edge later
            checks++; if (b_ovalid !== 1'b1 || b_result !== e) begin errors++;
                $display("FAIL b2b_capture n=%0d got vld=%b res=%h exp 1/%h", n, b_ovalid, b_result, e); end
            tick();                               // release
            checks++; if (b_count !== 8'(n + 1) || b_ready !== 1'b1) begin errors++;
                $display("FAIL b2b_count n=%0d got cnt=%0d rdy=%b exp %0d/1", n, b_count, b_ready, 8'(n + 1)); end
        end
        b_valid = 1'b0; b_iready = 1'b0;
        checks++; if (b_count !== 8'd0) begin errors++;
            $display("FAIL b2b_wrap got %0d exp 0", b_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_settle();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_add_ctrl.md
Name: multicycle_add_ctrl

Overview:
Control stage that drives the operand inputs of the combinational ripple-carry adder and captures its (WIDTH+1)-bit result. Accepts operand pairs on a valid/ready input handshake and holds them stable on the adder inputs for a programmable number of settle cycles, treating the slow carry chain as a multicycle path. It then registers the sum and presents it on a valid/ready output handshake. Sits directly around the adder: its o_add1/o_add2 feed the adder inputs, and the adder's result returns on i_sum.

Parameters:
WIDTH, 8, operand width; must match the adder's WIDTH.
SETTLE, 3, clock edges between operand launch and result capture; must be >= 1; the internal counter is $clog2(SETTLE+1) bits.

Ports:
i_clk  input  1  single clock, rising edge.
i_rst_n  input  1  asynchronous, active-low reset.
i_valid  input  1  operand pair on i_a/i_b is valid.
o_ready  output  1  block can accept an operand pair.
i_a  input  WIDTH  operand 1.
i_b  input  WIDTH  operand 2.
o_add1  output  WIDTH  registered operand 1 to the adder i_add1.
o_add2  output  WIDTH  registered operand 2 to the adder i_add2.
i_sum  input  WIDTH+1  adder o_result (carry-out in MSB).
o_valid  output  1  o_result holds a captured sum.
i_ready  input  1  downstream accepts o_result.
o_result  output  WIDTH+1  captured sum.
o_busy  output  1  high in any state other than IDLE.
o_count  output  8  completed transactions, modulo 256.

Behaviour:
- Reset (asynchronous assert, synchronous to i_clk on release): state IDLE; o_add1, o_add2, o_result, o_count and the settle counter = 0; o_valid = 0; o_busy = 0; o_ready = 1.
- FSM states are IDLE, SETTLE and HOLD. All outputs are registered except the decoded o_ready (IDLE) and o_busy (not IDLE).
- IDLE: o_ready = 1. On an edge with i_valid = 1: load o_add1 <= i_a, o_add2 <= i_b, counter <= SETTLE-1, go to SETTLE. With i_valid = 0, stay in IDLE and leave all registers unchanged.
- SETTLE: if the counter is not 0, decrement it. If the counter is 0: o_result <= i_sum, o_valid <= 1, go to HOLD. i_sum is sampled only on this edge; glitches earlier in the window are ignored.
- HOLD: o_valid = 1 and o_result stays stable until an edge with i_ready = 1. On that edge: o_valid <= 0, o_count <= o_count + 1 (wraps 255 -> 0), go to IDLE.
- Latency: if the operands are accepted at edge k, o_result is captured and o_valid rises at edge k+SETTLE.
- Throughput: with i_ready held high, minimum issue period is SETTLE+2 cycles.
- o_add1 and o_add2 hold their values through SETTLE, HOLD and the following IDLE; they change only on acceptance.
- Only IDLE accepts operands. In SETTLE and HOLD, i_valid and the i_a/i_b values are ignored and o_ready = 0.
- i_ready is ignored outside HOLD.
- The sum is never recomputed or truncated. o_result is exactly i_sum at the capture edge, all WIDTH+1 bits.
- Reset asserted mid-operation (SETTLE or HOLD): immediate return to reset values. A pending result is discarded and not counted.

Test Plan:
1. Reset with random inputs toggling -> all outputs 0 except o_ready = 1; after release, outputs stay idle until i_valid is asserted.
2. SETTLE=3, bench adder model with 25 ns delay at 10 ns clock; accept i_a = 8'h0F, i_b = 8'h01 at edge k -> o_add1/o_add2 = 0F/01 from edge k; o_valid rises at edge k+3 with o_result = 9'h010; o_count = 1 after the handshake.
3. Carry cases: 8'hFF + 8'h01 -> o_result = 9'h100; 8'hFF + 8'hFF -> 9'h1FE; 8'h00 + 8'h00 -> 9'h000 with o_valid = 1.
4. Backpressure: hold i_ready = 0 for 5 cycles in HOLD while driving i_valid = 1 with new operands -> o_result, o_add1 and o_add2 stable; o_ready = 0; o_count unchanged; after i_ready rises, the next operands are accepted one cycle later.
5. Assert i_rst_n low during SETTLE (counter = 1) -> outputs at reset values immediately, o_count not incremented; the next transaction 8'h80 + 8'h80 completes with 9'h100.
6. SETTLE=1 build: capture at edge k+1 and back-to-back issue period of 3 cycles. Run 256 transactions -> o_count wraps to 0.
